branch_predictor: RTL

Dynamic branch predictor and misprediction resolver for the pipelined RISC-V core. Consumes the decoded `beq`/`bne` flags in ID and supplies a taken/not-taken prediction plus target. Tracks each predicted branch into EX, compares it with the resolved outcome, and issues a redirect and flush on mismatch. Also updates the 2-bit saturating counters and keeps branch and misprediction statistics.

---
 rtl/branch_predictor.sv | 112 +++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Dynamic 2-bit branch predictor with ID/EX tracking, misprediction redirect and statistics.
// Define BRPRED_BHT_EN for a PC-indexed table of ENTRIES counters; otherwise one global counter.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             bubble,
  input  logic [31:0]      id_pc,
  input  logic             id_beq,
  input  logic             id_bne,
  input  logic [31:0]      id_imm,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             ex_taken,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  function automatic logic [1:0] sat_update(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'b01;
    else       return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  logic        is_br;
  logic        commit;
  logic [1:0]  lookup_ctr;
  logic        ex_valid;
  logic        ex_pred;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;

  assign is_br       = id_beq | id_bne;
  assign pred_taken  = is_br & lookup_ctr[1];
  assign pred_target = id_pc + id_imm;

  // ex_valid marks a predicted branch sitting in EX; it resolves (and is consumed)
  // on the first non-stall edge, with ex_taken sampled only while ex_valid is high.
  assign mispredict = ex_valid & (ex_taken ^ ex_pred);
  assign commit     = ex_valid & ~stall;

  // Outside a mispredict the fall-through of the EX slot is shown.
  always_comb begin
    redirect_pc = ex_pc + 32'd4;
    if (mispredict && !ex_pred) redirect_pc = ex_target;
  end

`ifdef BRPRED_BHT_EN
  localparam int IDX_W = $clog2(ENTRIES);

  logic [IDX_W-1:0] id_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [1:0]       ctr [ENTRIES];

  assign id_idx     = id_pc[IDX_W+1:2];
  assign lookup_ctr = ctr[id_idx];

  always_ff @(posedge clk) begin
    if (rst)        ex_idx <= '0;
    else if (!stall) ex_idx <= id_idx;
  end

  // Lookup reads the pre-update value; a same-index write shows up next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b01;
    end else if (commit) begin
      ctr[ex_idx] <= sat_update(ctr[ex_idx], ex_taken);
    end
  end
`else
  logic [1:0] ctr;

  assign lookup_ctr = ctr;

  always_ff @(posedge clk) begin
    if (rst)         ctr <= 2'b01;
    else if (commit) ctr <= sat_update(ctr, ex_taken);
  end
`endif

  // A mispredict squashes the ID instruction, so it never enters the EX slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_pred   <= 1'b0;
      ex_pc     <= 32'd0;
      ex_target <= 32'd0;
    end else if (!stall) begin
      ex_valid  <= is_br & ~bubble & ~mispredict;
      ex_pred   <= pred_taken;
      ex_pc     <= id_pc;
      ex_target <= pred_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt   <= '0;
      miss_cnt <= '0;
    end else if (commit) begin
      if (br_cnt != '1)                miss_cnt <= miss_cnt;
      if (br_cnt != '1)                br_cnt   <= br_cnt + 1'b1;
      if (mispredict && miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
    end
  end

endmodule
